// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by the transmit buffer and its FIFO.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } txbuf_state_e;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with occupancy and flush.
// Push is refused when full or flushing; pop is ignored when empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int W     = UART_DATA_W,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  // Next pointers and occupancy; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case (1'b1)
        do_push & ~do_pop: level_d = level_q + LW'(1);
        do_pop & ~do_push: level_d = level_q - LW'(1);
        default:           level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus drain FSM feeding uart_tx one frame at a time.
// Optional refused-write counter: define UART_TXBUF_OVF_CNT_EN.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_W  = UART_DATA_W,
  parameter int DEPTH   = 16,
  parameter int BUSY_TO = 64,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [LW-1:0]     level,
  output logic              empty,
`ifdef UART_TXBUF_OVF_CNT_EN
  output logic [15:0]       ovf_cnt,
`endif
  output logic              to_err
);

  localparam int CW = cnt_width(BUSY_TO);

  txbuf_state_e      state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              to_err_q, to_err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pop;
  logic              full;
  logic [DATA_W-1:0] head;

  uart_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (head),
    .flush (flush),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign wr_ready = ~full;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign to_err   = to_err_q;

  // Drain FSM: launch a byte, wait for busy to rise, then to fall.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    to_err_d   = 1'b0;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TO - 1)) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      to_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      to_err_q   <= to_err_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef UART_TXBUF_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  assign ovf_cnt = ovf_q;

  // Saturating count of refused writes; flush clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (flush) begin
      ovf_d = '0;
    end else if (wr_valid && !wr_ready && ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer with a uart_tx model.
// Define UART_TXBUF_OVF_CNT_EN to also check ovf_cnt.
module tb_uart_tx_buffer;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int BUSY_TO = 64;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          flush    = 1'b0;
  logic          tx_busy  = 1'b0;
  logic          wr_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [LW-1:0] level;
  logic          empty;
  logic          to_err;
`ifdef UART_TXBUF_OVF_CNT_EN
  logic [15:0]   ovf_cnt;
  int            ovf_m = 0;
`endif

  uart_tx_buffer #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .flush    (flush),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .level    (level),
    .empty    (empty),
`ifdef UART_TXBUF_OVF_CNT_EN
    .ovf_cnt  (ovf_cnt),
`endif
    .to_err   (to_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic          hold = 1'b0;
  logic          dead = 1'b0;
  logic          pending_to = 1'b0;
  logic          in_frame = 1'b0;
  logic [DW-1:0] frame_byte = '0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            left = 0;
  int            n_starts = 0;
  int            n_toerr = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference FIFO: bytes accepted by the buffer and not yet launched.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
`ifdef UART_TXBUF_OVF_CNT_EN
      ovf_m = 0;
`endif
    end else if (flush) begin
      exp_q.delete();
`ifdef UART_TXBUF_OVF_CNT_EN
      ovf_m = 0;
`endif
    end else if (wr_valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(wr_data);
`ifdef UART_TXBUF_OVF_CNT_EN
      else if (ovf_m < 65535) ovf_m++;
`endif
    end
  end

  // Monitor plus uart_tx model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      tx_busy    = 1'b0;
      in_frame   = 1'b0;
      pending_to = 1'b0;
      left       = 0;
    end else begin
      if (tx_start) begin
        n_starts++;
        check("start_vs_busy", 32'(tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_start: got tx_data %0h, expected no start",
                   tx_data);
        end else begin
          check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        start_cyc  = cyc;
        frame_byte = tx_data;
        if (dead) pending_to = 1'b1;
        else      in_frame   = 1'b1;
      end
      check("level", 32'(level), 32'(exp_q.size()));
      check("wr_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
`ifdef UART_TXBUF_OVF_CNT_EN
      check("ovf_cnt", 32'(ovf_cnt), 32'(ovf_m));
`endif
      if (to_err) begin
        n_toerr++;
        check("to_err_expected", 32'(pending_to), 32'd1);
        check("to_err_delay", 32'(cyc - start_cyc), 32'(BUSY_TO));
        pending_to = 1'b0;
      end else if (pending_to && (cyc - start_cyc) > BUSY_TO) begin
        n_cmp++;
        n_bad++;
        $display("FAIL to_err_missing: got none after %0d cycles, expected %0d",
                 cyc - start_cyc, BUSY_TO);
        pending_to = 1'b0;
      end
      if (in_frame && tx_busy)
        check("tx_data_stable", 32'(tx_data), 32'(frame_byte));
      if (hold) begin
        tx_busy = 1'b1;
        left    = 0;
      end else if (tx_start && !dead) begin
        tx_busy = 1'b1;
        left    = int'($urandom_range(2, 9));
      end else if (tx_busy) begin
        if (left == 0) begin
          tx_busy  = 1'b0;
          in_frame = 1'b0;
        end else begin
          left--;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (!(exp_q.size() == 0 && !tx_busy && !pending_to) && k < max) begin
      step();
      k++;
    end
    if (k >= max) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no idle within %0d cycles, expected idle", name, max);
    end
    repeat (2) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int k;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_to_err", 32'(to_err), 32'd0);
    repeat (2) step();
    rst = 1'b0;

    // Single byte latency
    step();
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    check("t1_level1", 32'(level), 32'd1);
    check("t1_no_start", 32'(tx_start), 32'd0);
    step();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'hA5);
    check("t1_level0", 32'(level), 32'd0);
    wait_idle("t1_idle", 100);

    // Push and pop in the same cycle at level 3
    hold = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(8'h30 + i);
      step();
    end
    wr_valid = 1'b0;
    step();
    check("pp_level3", 32'(level), 32'd3);
    hold = 1'b0;
    k = 0;
    while (tx_busy && k < 10) begin
      step();
      k++;
    end
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    step();
    wr_valid = 1'b0;
    check("pp_start", 32'(tx_start), 32'd1);
    check("pp_level", 32'(level), 32'd3);
    wait_idle("pp_idle", 300);

    // Fill past capacity, then drain in order
    hold = 1'b1;
    step();
    for (int i = 0; i <= DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(i);
      step();
    end
    wr_valid = 1'b0;
    check("fill_level", 32'(level), 32'(DEPTH));
    check("fill_ready", 32'(wr_ready), 32'd0);
`ifdef UART_TXBUF_OVF_CNT_EN
    check("fill_ovf", 32'(ovf_cnt), 32'd1);
`endif
    snap = n_starts;
    hold = 1'b0;
    wait_idle("drain_idle", 1000);
    check("drain_starts", 32'(n_starts - snap), 32'(DEPTH));

    // Busy timeout
    dead = 1'b1;
    snap = n_toerr;
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    step();
    wr_valid = 1'b0;
    wait_idle("to_idle", 300);
    check("to_count", 32'(n_toerr - snap), 32'd1);
    dead = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hC3;
    step();
    wr_valid = 1'b0;
    wait_idle("after_to_idle", 100);

    // Flush while a frame is in flight
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(8'h90 + i);
      step();
    end
    wr_valid = 1'b0;
    k = 0;
    while (!(tx_busy && exp_q.size() > 0) && k < 50) begin
      step();
      k++;
    end
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_ready", 32'(wr_ready), 32'd1);
    snap = n_starts;
    repeat (30) step();
    check("flush_no_start", 32'(n_starts - snap), 32'd0);
    wait_idle("flush_idle", 100);

    // Random traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      wr_valid = ($urandom % 3) != 0;
      wr_data  = DW'($urandom);
      flush    = tx_busy && (($urandom % 40) == 0);
      step();
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    wait_idle("rand_idle", 2000);

    // Asynchronous reset during WAIT_DONE
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(8'hB1 + i);
      step();
    end
    wr_valid = 1'b0;
    k = 0;
    while (!tx_busy && k < 20) begin
      step();
      k++;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx_start", 32'(tx_start), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_wr_ready", 32'(wr_ready), 32'd1);
    check("arst_to_err", 32'(to_err), 32'd0);
`ifdef UART_TXBUF_OVF_CNT_EN
    check("arst_ovf", 32'(ovf_cnt), 32'd0);
`endif
    repeat (2) step();
    rst = 1'b0;
    step();
    wr_valid = 1'b1;
    wr_data  = 8'h6E;
    step();
    wr_valid = 1'b0;
    wait_idle("post_rst_idle", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
